// File: rtl/instr_sequencer_if.sv
// Program-load and issue signals shared between instr_sequencer and whatever drives it.
// The master side loads the store and starts runs; the slave side is the sequencer.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_W      = 4
);
    logic                   prog_we;
    logic [ADDR_W-1:0]      prog_addr;
    logic [INSTR_WIDTH-1:0] prog_wdata;
    logic                   start;
    logic                   abort;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [ADDR_W-1:0]      pc;
    logic                   busy;
    logic                   done;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, abort,
        input  instruction, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, abort,
        output instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program-driven instruction source for simple_cpu: each stored word is held for a class-dependent cycle count.
// Optional macro INSTR_SEQ_LOOP_EN makes the program restart at address 0 instead of finishing.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PROG_DEPTH  = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_ALU    = 3,
    parameter int HOLD_STORE  = 3,
    parameter int HOLD_LOAD   = 4
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] mem [PROG_DEPTH];
    logic [INSTR_WIDTH-1:0] instruction_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic [ADDR_W-1:0]      pc_q;
    logic [CNT_W-1:0]       hold_cnt;

    logic [ADDR_W-1:0]      next_pc;
    logic [INSTR_WIDTH-1:0] next_word;
    logic [INSTR_WIDTH-1:0] first_word;
    logic                   at_end;
    logic                   write_ok;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
        return w[INSTR_WIDTH-1 -: 2] == 2'b00;
    endfunction

    // Counter reload is hold-1 because the load edge itself counts as the first held cycle.
    function automatic logic [CNT_W-1:0] hold_reload(input logic [INSTR_WIDTH-1:0] w);
        case (w[INSTR_WIDTH-1 -: 2])
            2'b01:   return CNT_W'(HOLD_ALU - 1);
            2'b10:   return CNT_W'(HOLD_LOAD - 1);
            2'b11:   return CNT_W'(HOLD_STORE - 1);
            default: return '0;
        endcase
    endfunction

    assign next_pc    = pc_q + ADDR_W'(1);
    assign next_word  = mem[next_pc];
    assign first_word = mem[0];
    assign at_end     = (pc_q == ADDR_W'(PROG_DEPTH - 1)) || is_halt(next_word);
    assign write_ok   = bus.prog_we && !bus.start && (state != ISSUE);

    // The store is only writable while no program is being issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            instruction_q <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pc_q          <= '0;
            hold_cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (is_halt(first_word)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            instruction_q <= first_word;
                            valid_q       <= 1'b1;
                            busy_q        <= 1'b1;
                            done_q        <= 1'b0;
                            pc_q          <= '0;
                            hold_cnt      <= hold_reload(first_word);
                        end
                    end else if (state == DONE && bus.abort) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        pc_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        instruction_q <= '0;
                        valid_q       <= 1'b0;
                        busy_q        <= 1'b0;
                        pc_q          <= '0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end else if (at_end) begin
`ifdef INSTR_SEQ_LOOP_EN
                        instruction_q <= first_word;
                        pc_q          <= '0;
                        hold_cnt      <= hold_reload(first_word);
`else
                        state         <= DONE;
                        instruction_q <= '0;
                        valid_q       <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
`endif
                    end else begin
                        instruction_q <= next_word;
                        pc_q          <= next_pc;
                        hold_cnt      <= hold_reload(next_word);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
